// File: rtl/dunit_regfile_dumper.sv
// Debug-unit register file dumper: walks the regfile debug read port and streams each word
// MSB-first as bytes to the UART TX over a valid/ready handshake.
module dunit_regfile_dumper #(
  parameter int unsigned NB_REG   = 32,
  parameter int unsigned NB_ADDR  = 5,
  parameter int unsigned N_REGS   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_dunit_addr,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned NB_BYTES = NB_REG / 8;
  localparam int unsigned NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [2:0]         LAT_RELOAD = 3'(READ_LAT - 1);
  localparam logic [NB_BCNT-1:0] BYTE_LAST  = NB_BCNT'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] ADDR_LAST  = NB_ADDR'(N_REGS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSend,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic [2:0]           lat_q, lat_d;
  logic [NB_BCNT-1:0]   byte_q, byte_d;
  logic [NB_REG-1:0]    shift_q, shift_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lat_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StWait;
          addr_d  = '0;
          lat_d   = LAT_RELOAD;
        end
      end
      StWait: begin
        if (lat_q == '0) begin
          shift_d = i_dunit_reg;
          byte_d  = BYTE_LAST;
          state_d = StSend;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      StSend: begin
        // The top byte of shift_q is the presented byte; it only moves on a transfer.
        if (i_tx_ready) begin
          shift_d = shift_q << 8;
          if (byte_q != '0) begin
            byte_d = byte_q - NB_BCNT'(1);
          end else if (addr_q != ADDR_LAST) begin
            addr_d  = addr_q + NB_ADDR'(1);
            lat_d   = LAT_RELOAD;
            state_d = StWait;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_dunit_addr = addr_q;
  assign o_tx_data    = shift_q[NB_REG-1 -: 8];
  assign o_tx_valid   = (state_q == StSend);
  assign o_busy       = (state_q == StWait) || (state_q == StSend);
  assign o_done       = (state_q == StDone);

endmodule

// File: tb/tb_dunit_regfile_dumper.sv
// Scoreboard bench for dunit_regfile_dumper: a 32-register/latency-1 instance and a
// 4-register/latency-3 instance, each fed by a behavioural register file model.
module tb_dunit_regfile_dumper;

  localparam int NA    = 32;
  localparam int NB    = 4;
  localparam int NBYTE = 4;
  localparam int LAT_B = 3;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0;
  logic [4:0] addr_a;
  logic [31:0] reg_a;
  logic [7:0] data_a;
  logic       valid_a, busy_a, done_a;
  logic       ready_a = 1'b1;

  logic       start_b = 1'b0;
  logic [1:0] addr_b;
  logic [31:0] reg_b;
  logic [7:0] data_b;
  logic       valid_b, busy_b, done_b;
  logic       ready_b = 1'b1;

  logic [31:0] rf_a [NA];
  logic [31:0] rf_b [NB];
  logic [1:0]  d1_b, d2_b;

  dunit_regfile_dumper #(
    .NB_REG  (32),
    .NB_ADDR (5),
    .N_REGS  (NA),
    .READ_LAT(1)
  ) u_dut_a (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start_a),
    .o_dunit_addr(addr_a),
    .i_dunit_reg (reg_a),
    .o_tx_data   (data_a),
    .o_tx_valid  (valid_a),
    .i_tx_ready  (ready_a),
    .o_busy      (busy_a),
    .o_done      (done_a)
  );

  dunit_regfile_dumper #(
    .NB_REG  (32),
    .NB_ADDR (2),
    .N_REGS  (NB),
    .READ_LAT(LAT_B)
  ) u_dut_b (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start_b),
    .o_dunit_addr(addr_b),
    .i_dunit_reg (reg_b),
    .o_tx_data   (data_b),
    .o_tx_valid  (valid_b),
    .i_tx_ready  (ready_b),
    .o_busy      (busy_b),
    .o_done      (done_b)
  );

  // Latency 1 is a same-cycle read; latency 3 adds two address pipeline stages.
  assign reg_a = rf_a[addr_a];
  always @(posedge clk) begin
    d1_b <= addr_b;
    d2_b <= d1_b;
  end
  assign reg_b = rf_b[d2_b];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] rx_a[$];
  logic [1:0] addr_seq_b[$];
  int bytes_a = 0, dones_a = 0, bytes_b = 0, dones_b = 0;
  bit hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] hold_data_a, hold_data_b;
  logic [1:0] last_addr_b = 2'd0;
  logic [1:0] max_addr_b  = 2'd0;
  bit rand_ready = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        check_eq("a_hold_valid", 32'(valid_a), 32'd1);
        check_eq("a_hold_data", 32'(data_a), 32'(hold_data_a));
      end
      if (valid_a && ready_a) begin
        if (exp_a.size() == 0) begin
          check_eq("a_extra_byte", 32'd1, 32'd0);
        end else begin
          e = exp_a.pop_front();
          check_eq("a_byte", 32'(data_a), 32'(e));
        end
        rx_a.push_back(data_a);
        bytes_a++;
      end
      hold_a      = valid_a && !ready_a;
      hold_data_a = data_a;
      if (done_a) dones_a++;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      hold_b = 1'b0;
    end else begin
      if (hold_b) check_eq("b_hold_data", 32'(data_b), 32'(hold_data_b));
      if (valid_b && ready_b) begin
        if (exp_b.size() == 0) begin
          check_eq("b_extra_byte", 32'd1, 32'd0);
        end else begin
          e = exp_b.pop_front();
          check_eq("b_byte", 32'(data_b), 32'(e));
        end
        bytes_b++;
      end
      hold_b      = valid_b && !ready_b;
      hold_data_b = data_b;
      if (done_b) dones_b++;
      if (addr_b != last_addr_b) begin
        addr_seq_b.push_back(addr_b);
        last_addr_b = addr_b;
      end
      if (addr_b > max_addr_b) max_addr_b = addr_b;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_a = rand_ready ? ($urandom_range(99) < 30) : 1'b1;
    end
  end

  task automatic push_dump_a();
    for (int i = 0; i < NA; i++)
      for (int b = NBYTE - 1; b >= 0; b--) exp_a.push_back(rf_a[i][8*b +: 8]);
  endtask

  task automatic push_dump_b();
    for (int i = 0; i < NB; i++)
      for (int b = NBYTE - 1; b >= 0; b--) exp_b.push_back(rf_b[i][8*b +: 8]);
  endtask

  task automatic pulse_start_a();
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
  endtask

  // Counts falling edges after the start-sampling edge up to and including the o_done cycle.
  task automatic wait_done_a(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_a && cyc < LIMIT);
    if (!done_a) check_eq("a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done_b(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_b && cyc < LIMIT);
    if (!done_b) check_eq("b_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bytes_a(input int n);
    int k = 0;
    while (bytes_a < n && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (bytes_a < n) check_eq("a_bytes_timeout", 32'(bytes_a), 32'(n));
  endtask

  initial begin
    int cyc, base_bytes, base_dones, rb;
    for (int i = 0; i < NA; i++) rf_a[i] = 32'h1122_3300 + 32'(i);
    for (int i = 0; i < NB; i++) rf_b[i] = 32'hF00D_0000 + 32'(i) * 32'h0001_0111;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_addr_a", 32'(addr_a), 32'd0);
    check_eq("rst_data_a", 32'(data_a), 32'd0);
    check_eq("rst_valid_a", 32'(valid_a), 32'd0);
    check_eq("rst_busy_a", 32'(busy_a), 32'd0);
    check_eq("rst_done_a", 32'(done_a), 32'd0);
    check_eq("rst_valid_b", 32'(valid_b), 32'd0);
    rst = 1'b0;

    // Test 1: full dump, ready always high.
    base_bytes = bytes_a;
    base_dones = dones_a;
    rb = rx_a.size();
    push_dump_a();
    pulse_start_a();
    wait_done_a(cyc);
    check_eq("t1_cycles", 32'(cyc), 32'(NA * (1 + NBYTE) + 1));
    repeat (3) @(posedge clk);
    check_eq("t1_bytes", 32'(bytes_a - base_bytes), 32'(NA * NBYTE));
    check_eq("t1_dones", 32'(dones_a - base_dones), 32'd1);
    check_eq("t1_queue", 32'(exp_a.size()), 32'd0);
    check_eq("t1_last_byte", 32'(rx_a[rb + NA * NBYTE - 1]), 32'h1F);

    // Test 2: random backpressure, r5 distinctive.
    rf_a[5] = 32'hDEAD_BEEF;
    rand_ready = 1'b1;
    base_bytes = bytes_a;
    base_dones = dones_a;
    rb = rx_a.size();
    push_dump_a();
    pulse_start_a();
    wait_done_a(cyc);
    repeat (3) @(posedge clk);
    rand_ready = 1'b0;
    check_eq("t2_bytes", 32'(bytes_a - base_bytes), 32'(NA * NBYTE));
    check_eq("t2_dones", 32'(dones_a - base_dones), 32'd1);
    check_eq("t2_b20", 32'(rx_a[rb + 20]), 32'hDE);
    check_eq("t2_b21", 32'(rx_a[rb + 21]), 32'hAD);
    check_eq("t2_b22", 32'(rx_a[rb + 22]), 32'hBE);
    check_eq("t2_b23", 32'(rx_a[rb + 23]), 32'hEF);

    // Test 3: start pulse mid-dump must be ignored.
    base_bytes = bytes_a;
    base_dones = dones_a;
    push_dump_a();
    pulse_start_a();
    wait_bytes_a(base_bytes + 40);
    pulse_start_a();
    wait_done_a(cyc);
    repeat (5) @(posedge clk);
    check_eq("t3_bytes", 32'(bytes_a - base_bytes), 32'(NA * NBYTE));
    check_eq("t3_dones", 32'(dones_a - base_dones), 32'd1);
    check_eq("t3_queue", 32'(exp_a.size()), 32'd0);

    // Test 4: asynchronous reset mid-dump, then a fresh dump from r0.
    base_bytes = bytes_a;
    push_dump_a();
    pulse_start_a();
    wait_bytes_a(base_bytes + 50);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("t4_addr", 32'(addr_a), 32'd0);
    check_eq("t4_data", 32'(data_a), 32'd0);
    check_eq("t4_valid", 32'(valid_a), 32'd0);
    check_eq("t4_busy", 32'(busy_a), 32'd0);
    check_eq("t4_done", 32'(done_a), 32'd0);
    exp_a.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    base_bytes = bytes_a;
    base_dones = dones_a;
    rb = rx_a.size();
    push_dump_a();
    pulse_start_a();
    wait_done_a(cyc);
    repeat (3) @(posedge clk);
    check_eq("t4_bytes", 32'(bytes_a - base_bytes), 32'(NA * NBYTE));
    check_eq("t4_dones", 32'(dones_a - base_dones), 32'd1);
    check_eq("t4_first", 32'(rx_a[rb]), 32'h11);
    check_eq("t4_r0_lsb", 32'(rx_a[rb + 3]), 32'h00);

    // Test 5: small regfile with read latency 3.
    push_dump_b();
    pulse_start_b();
    wait_done_b(cyc);
    check_eq("t5_cycles", 32'(cyc), 32'(NB * (LAT_B + NBYTE) + 1));
    repeat (3) @(posedge clk);
    check_eq("t5_bytes", 32'(bytes_b), 32'(NB * NBYTE));
    check_eq("t5_dones", 32'(dones_b), 32'd1);
    check_eq("t5_queue", 32'(exp_b.size()), 32'd0);
    check_eq("t5_addr_max", 32'(max_addr_b), 32'd3);
    check_eq("t5_addr_changes", 32'(addr_seq_b.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("t5_addr_seq", 32'(addr_seq_b[i]), 32'((i + 1) % 4));

    // Test 6: start held high gives back-to-back dumps with one idle cycle between them.
    base_bytes = bytes_a;
    base_dones = dones_a;
    push_dump_a();
    push_dump_a();
    @(posedge clk);
    #1 start_a = 1'b1;
    wait_done_a(cyc);
    @(negedge clk);
    check_eq("t6_idle_busy", 32'(busy_a), 32'd0);
    check_eq("t6_idle_done", 32'(done_a), 32'd0);
    @(negedge clk);
    check_eq("t6_restart_busy", 32'(busy_a), 32'd1);
    wait_done_a(cyc);
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    check_eq("t6_bytes", 32'(bytes_a - base_bytes), 32'(2 * NA * NBYTE));
    check_eq("t6_dones", 32'(dones_a - base_dones), 32'd2);
    check_eq("t6_queue", 32'(exp_a.size()), 32'd0);
    check_eq("t6_final_busy", 32'(busy_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
